// File: rtl/router_in_port.sv
// One router input lane: parses the serial header (address + pad), presents a per-packet
// destination selector to the crossbar and forwards the payload one cycle late.
module router_in_port #(
    parameter int ADDR_W  = 1,
    parameter int PAD_CYC = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_i,
    input  logic              valid_i,
    input  logic              din,
    output logic [ADDR_W-1:0] dest_o,
    output logic              dest_vld_o,
    output logic              frame_o,
    output logic              valid_o,
    output logic              dout,
    output logic [CNT_W-1:0]  data_cnt_o,
    output logic              err_o
);

    localparam int AIDX_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int PCNT_W = (PAD_CYC > 1) ? $clog2(PAD_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        DATA,
        FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [AIDX_W-1:0] addr_idx;
    logic [PCNT_W-1:0] pad_cnt;

    logic start;
    logic addr_smp;
    logic clr_dest;
    logic err_nxt;
    logic fwd;
    logic cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        addr_smp  = 1'b0;
        clr_dest  = 1'b0;
        err_nxt   = 1'b0;
        fwd       = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!frame_i) begin
                    start     = 1'b1;
                    state_nxt = (ADDR_W > 1) ? ADDR : PAD;
                end
            end
            ADDR: begin
                if (frame_i) begin
                    err_nxt   = 1'b1;
                    clr_dest  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    addr_smp = 1'b1;
                    if (addr_idx == AIDX_W'(ADDR_W - 1)) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (!valid_i || frame_i) begin
                    err_nxt   = 1'b1;
                    clr_dest  = 1'b1;
                    state_nxt = IDLE;
                end else if (pad_cnt == PCNT_W'(PAD_CYC - 1)) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (frame_i && valid_i) begin
                    // abort: nothing is forwarded, so the crossbar sees idle next cycle
                    err_nxt   = 1'b1;
                    clr_dest  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    fwd     = 1'b1;
                    cnt_inc = !valid_i;
                    if (frame_i) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // a new header may start while the last bit is still on the outputs
                if (!frame_i) begin
                    start     = 1'b1;
                    state_nxt = (ADDR_W > 1) ? ADDR : PAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // header capture and payload counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_o     <= '0;
            addr_idx   <= '0;
            pad_cnt    <= '0;
            data_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o   <= err_nxt;
            pad_cnt <= (state == PAD) ? pad_cnt + 1'b1 : '0;
            if (start) begin
                dest_o     <= ADDR_W'(din);
                addr_idx   <= AIDX_W'(1);
                data_cnt_o <= '0;
            end else if (clr_dest) begin
                dest_o <= '0;
            end else if (addr_smp) begin
                dest_o   <= dest_o | (ADDR_W'(din) << addr_idx);
                addr_idx <= addr_idx + 1'b1;
            end
            if (cnt_inc) begin
                data_cnt_o <= sat_inc(data_cnt_o);
            end
        end
    end

    // forwarding stage: outputs idle high unless the cycle was sourced from DATA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_o <= 1'b1;
            valid_o <= 1'b1;
            dout    <= 1'b1;
        end else begin
            frame_o <= fwd ? frame_i : 1'b1;
            valid_o <= fwd ? valid_i : 1'b1;
            dout    <= fwd ? din : 1'b1;
        end
    end

    assign dest_vld_o = (state == DATA) || (state == FLUSH);

endmodule

// File: tb/tb_router_in_port.sv
// Scoreboard bench for router_in_port: an 8-bit-counter lane and a 2-bit-counter lane
// share the same stimulus; expected outputs are queued per driven cycle.
module tb_router_in_port;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_i = 1'b1;
    logic valid_i = 1'b1;
    logic din = 1'b1;

    logic [0:0] dest_o, s_dest_o;
    logic dest_vld_o, frame_o, valid_o, dout, err_o;
    logic s_dest_vld_o, s_frame_o, s_valid_o, s_dout, s_err_o;
    logic [7:0] data_cnt_o;
    logic [1:0] s_data_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]  stim_q[$];
    logic [21:0] exp_q[$];

    localparam logic [5:0]  OUT_RST = 6'b0_0_111_0;
    localparam logic [21:0] VEC_RST = {OUT_RST, 8'd0, OUT_RST, 2'd0};

    router_in_port #(.ADDR_W(1), .PAD_CYC(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_i(frame_i), .valid_i(valid_i), .din(din),
        .dest_o(dest_o), .dest_vld_o(dest_vld_o), .frame_o(frame_o), .valid_o(valid_o),
        .dout(dout), .data_cnt_o(data_cnt_o), .err_o(err_o)
    );

    router_in_port #(.ADDR_W(1), .PAD_CYC(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .frame_i(frame_i), .valid_i(valid_i), .din(din),
        .dest_o(s_dest_o), .dest_vld_o(s_dest_vld_o), .frame_o(s_frame_o), .valid_o(s_valid_o),
        .dout(s_dout), .data_cnt_o(s_data_cnt_o), .err_o(s_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {dest_o, dest_vld_o, frame_o, valid_o, dout, err_o, data_cnt_o,
                s_dest_o, s_dest_vld_o, s_frame_o, s_valid_o, s_dout, s_err_o, s_data_cnt_o};
    endfunction

    // fvd = {frame_i, valid_i, din} for one cycle; outs = {dest, dest_vld, frame, valid, dout, err}
    // expected right after the edge that consumes it; cnt = full-width payload count then.
    task automatic add(input logic [2:0] fvd, input logic [5:0] outs, input int cnt);
        stim_q.push_back(fvd);
        exp_q.push_back({outs, 8'(cnt), outs, 2'((cnt > 3) ? 3 : cnt)});
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== VEC_RST) begin
            n_bad++;
            $display("FAIL reset got %b want %b", obs(), VEC_RST);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [21:0] g, e;
        int row = 0;
        add(3'b011, 6'b1_0_111_0, 0);
        add(3'b010, 6'b1_1_111_0, 0);
        add(3'b001, 6'b1_1_001_0, 1);
        add(3'b000, 6'b1_1_000_0, 2);
        add(3'b001, 6'b1_1_001_0, 3);
        add(3'b101, 6'b1_1_101_0, 4);
        add(3'b111, 6'b1_0_111_0, 4);
        while (stim_q.size() != 0) begin
            {frame_i, valid_i, din} = stim_q.pop_front();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL basic[%0d] got %b want %b", row, g, e);
            end
            row++;
        end
    endtask

    task automatic test_bubble();
        logic [21:0] g, e;
        int row = 0;
        add(3'b010, 6'b0_0_111_0, 0);
        add(3'b011, 6'b0_1_111_0, 0);
        add(3'b001, 6'b0_1_001_0, 1);
        add(3'b010, 6'b0_1_010_0, 1);
        add(3'b000, 6'b0_1_000_0, 2);
        add(3'b101, 6'b0_1_101_0, 3);
        add(3'b111, 6'b0_0_111_0, 3);
        while (stim_q.size() != 0) begin
            {frame_i, valid_i, din} = stim_q.pop_front();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL bubble[%0d] got %b want %b", row, g, e);
            end
            row++;
        end
    endtask

    task automatic test_header_error();
        logic [21:0] g, e;
        int row = 0;
        add(3'b011, 6'b1_0_111_0, 0);
        add(3'b001, 6'b0_0_111_1, 0);
        add(3'b111, 6'b0_0_111_0, 0);
        add(3'b011, 6'b1_0_111_0, 0);
        add(3'b111, 6'b0_0_111_1, 0);
        add(3'b111, 6'b0_0_111_0, 0);
        while (stim_q.size() != 0) begin
            {frame_i, valid_i, din} = stim_q.pop_front();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL hdr_err[%0d] got %b want %b", row, g, e);
            end
            row++;
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] g, e;
        int row = 0;
        add(3'b011, 6'b1_0_111_0, 0);
        add(3'b010, 6'b1_1_111_0, 0);
        add(3'b000, 6'b1_1_000_0, 1);
        add(3'b101, 6'b1_1_101_0, 2);
        add(3'b010, 6'b0_0_111_0, 0);
        add(3'b011, 6'b0_1_111_0, 0);
        add(3'b001, 6'b0_1_001_0, 1);
        add(3'b100, 6'b0_1_100_0, 2);
        add(3'b111, 6'b0_0_111_0, 2);
        while (stim_q.size() != 0) begin
            {frame_i, valid_i, din} = stim_q.pop_front();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b[%0d] got %b want %b", row, g, e);
            end
            row++;
        end
    endtask

    task automatic test_abort_reset();
        logic [21:0] g, e;
        int row = 0;
        add(3'b011, 6'b1_0_111_0, 0);
        add(3'b010, 6'b1_1_111_0, 0);
        add(3'b000, 6'b1_1_000_0, 1);
        add(3'b110, 6'b0_0_111_1, 1);
        add(3'b111, 6'b0_0_111_0, 1);
        add(3'b011, 6'b1_0_111_0, 0);
        add(3'b010, 6'b1_1_111_0, 0);
        add(3'b000, 6'b1_1_000_0, 1);
        while (stim_q.size() != 0) begin
            {frame_i, valid_i, din} = stim_q.pop_front();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL abort[%0d] got %b want %b", row, g, e);
            end
            row++;
        end
        frame_i = 1'b0;
        valid_i = 1'b0;
        din = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== VEC_RST) begin
            n_bad++;
            $display("FAIL async_reset got %b want %b", obs(), VEC_RST);
        end
        @(posedge clk);
        #1;
        frame_i = 1'b1;
        valid_i = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== VEC_RST) begin
            n_bad++;
            $display("FAIL reset_release got %b want %b", obs(), VEC_RST);
        end
    endtask

    task automatic test_saturation();
        logic [21:0] g, e;
        logic b;
        int row = 0;
        add(3'b010, 6'b0_0_111_0, 0);
        add(3'b010, 6'b0_1_111_0, 0);
        for (int i = 1; i <= 5; i++) begin
            b = 1'(i & 1);
            add({2'b00, b}, {4'b0_1_00, b, 1'b0}, i);
        end
        add(3'b100, 6'b0_1_100_0, 6);
        add(3'b111, 6'b0_0_111_0, 6);
        while (stim_q.size() != 0) begin
            {frame_i, valid_i, din} = stim_q.pop_front();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL sat[%0d] got %b want %b", row, g, e);
            end
            row++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_header_error();
        test_back_to_back();
        test_abort_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
